// File: rtl/matmul_host_if_if.sv
// matmul_host_if_if: operand input stream and result output stream
// between a host and matmul_host_if.
interface matmul_host_if_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matmul_host_if.sv
// matmul_host_if: loads X then Y into the operand BRAMs, starts the core,
// then streams Z out of its BRAM through a 2-entry output FIFO.
module matmul_host_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int VECTOR_SIZE = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    matmul_host_if_if.slave       host,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic                  y_wr_en,
    output logic                  start,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout
);
    localparam int N  = VECTOR_SIZE * VECTOR_SIZE;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [CW-1:0] NWORDS = CW'(N);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [2:0] {
        S_LOAD_X,
        S_LOAD_Y,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         rd_cnt;
    logic                  wait_armed;
    logic                  rd_pend;
    logic                  rd_pend_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;

    logic       accept;
    logic       last_word;
    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] demand;

    assign host.in_ready  = (state == S_LOAD_X) || (state == S_LOAD_Y);
    assign host.out_valid = (occ != 2'd0);
    assign host.out_data  = fifo_data[rd_ptr];
    assign host.out_last  = host.out_valid && fifo_last[rd_ptr];

    assign accept    = host.in_valid && host.in_ready;
    assign last_word = (cnt == LAST);
    assign pop       = host.out_valid && host.out_ready;
    assign push      = rd_pend;

    // Reads in flight count against FIFO space so a returning word
    // always has a slot, even under full backpressure.
    assign demand = {1'b0, occ} + {2'b00, rd_pend};
    assign issue  = (state == S_DRAIN) && (rd_cnt < NWORDS)
                 && (demand < (3'd2 + {2'b00, pop}));

    assign z_rd_addr = rd_cnt[ADDR_WIDTH-1:0];
    assign start     = (state == S_START);
    assign busy      = !((state == S_LOAD_X) && (cnt == '0));

    always_comb begin
        state_n = state;
        unique case (state)
            S_LOAD_X: if (accept && last_word) state_n = S_LOAD_Y;
            S_LOAD_Y: if (accept && last_word) state_n = S_START;
            S_START:  state_n = S_WAIT;
            S_WAIT:   if (wait_armed && done) state_n = S_DRAIN;
            S_DRAIN:  if (pop && host.out_last) state_n = S_LOAD_X;
            default:  state_n = S_LOAD_X;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_LOAD_X;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            wait_armed <= 1'b0;
            x_din      <= '0;
            x_wr_addr  <= '0;
            x_wr_en    <= 1'b0;
            y_din      <= '0;
            y_wr_addr  <= '0;
            y_wr_en    <= 1'b0;
        end else begin
            x_wr_en <= accept && (state == S_LOAD_X);
            y_wr_en <= accept && (state == S_LOAD_Y);
            if (accept) begin
                cnt <= last_word ? '0 : cnt + ONE;
                if (state == S_LOAD_X) begin
                    x_din     <= host.in_data;
                    x_wr_addr <= cnt[ADDR_WIDTH-1:0];
                end else begin
                    y_din     <= host.in_data;
                    y_wr_addr <= cnt[ADDR_WIDTH-1:0];
                end
            end
            // Low in the first WAIT cycle so a leftover done is ignored.
            wait_armed <= (state == S_WAIT);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= issue && (rd_cnt == LAST);
            if (issue) rd_cnt <= rd_cnt + ONE;
            if (push) begin
                fifo_data[wr_ptr] <= z_dout;
                fifo_last[wr_ptr] <= rd_pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop && host.out_last) begin
                rd_cnt <= '0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                occ    <= 2'd0;
            end
        end
    end
endmodule

// File: doc/matmul_host_if.md
# matmul_host_if

Host-side streaming front end for the matrix-multiply core subsystem (core plus X/Y/Z block RAMs). Accepts one valid/ready input stream carrying X then Y, writes both operands into the X and Y BRAM write ports, and pulses `start`. It waits for `done`, then reads the Z BRAM and emits the result as a valid/ready output stream with a last marker. It is the initiator/reader counterpart of the subsystem's host ports.

## Interface
- DATA_WIDTH, 32, word width of every stream and BRAM port
- ADDR_WIDTH, 12, BRAM address width; must satisfy 2^ADDR_WIDTH >= N
- VECTOR_SIZE, 64, matrix dimension; N = VECTOR_SIZE*VECTOR_SIZE words per matrix

- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1 / 1  input handshake; a word transfers when both are 1
- in_data  in  DATA_WIDTH  N words of X (row-major), then N words of Y
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_data  out  DATA_WIDTH  Z word, row-major
- out_last  out  1  high with Z word N-1 only
- busy  out  1  high from the first accepted X word until the last Z word transfers
- x_din, x_wr_addr, x_wr_en  out  DATA_WIDTH, ADDR_WIDTH, 1  X BRAM write port
- y_din, y_wr_addr, y_wr_en  out  DATA_WIDTH, ADDR_WIDTH, 1  Y BRAM write port
- start  out  1  one-cycle pulse to the core
- done  in  1  core completion
- z_rd_addr  out  ADDR_WIDTH  Z BRAM read address
- z_dout  in  DATA_WIDTH  Z BRAM read data, valid one cycle after z_rd_addr

## Operation
- FSM states: LOAD_X (reset state), LOAD_Y, START, WAIT, DRAIN.
- LOAD_X: in_ready=1. Each accepted word is written to X at address cnt, and cnt increments. On the accept with cnt==N-1, cnt goes to 0 and the FSM moves to LOAD_Y.
- LOAD_Y: same as LOAD_X but targets Y. After accepting word N-1, the FSM moves to START.
- START: in_ready=0. start=1 for exactly this one cycle. The FSM moves to WAIT.
- WAIT: done is ignored in the first WAIT cycle (guard against a stale done). In any later cycle, done=1 moves the FSM to DRAIN.
- DRAIN: issues reads at z_rd_addr = rd_cnt for 0..N-1. Returned data goes into a 2-entry output FIFO that drives out_*.
  - A read is issued in a cycle only if (fifo_occupancy + reads_in_flight - pop_this_cycle) < 2.
  - A pop is out_valid & out_ready.
- DRAIN exit: after the pop with out_last=1, the FSM returns to LOAD_X with all counters 0 and busy=0 in the next cycle.
- BRAM write outputs are registered. x_/y_ din, addr and wr_en appear one cycle after the accepting handshake. wr_en is 1 for exactly one cycle per word.
- cnt and rd_cnt are ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH does not overflow.
- in_valid is ignored outside LOAD_X/LOAD_Y. out_ready is ignored outside DRAIN.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, start=0, x_wr_en=0, y_wr_en=0, all addresses and din=0. FIFO is empty and counters are 0.
- Reset mid-operation (any state) aborts the run. Outputs take their reset values the cycle after reset is sampled. FIFO contents are discarded and no further BRAM writes or start are issued.
- Write latency: accept at cycle t gives wr_en=1 at t+1.
- Start timing: the last Y accept at t gives the Y write at t+1, START at t+1, and the start pulse at t+1. The Y write and start are registered together, so the Y data lands before the core's first read at t+2 or later.
- First Z word: done sampled at t gives DRAIN at t+1 and the first read at t+1. out_valid=1 at t+3 (z_dout arrives at t+2, FIFO register at t+3).
- Throughput: with out_ready held at 1, one Z word per cycle after the first. Backpressure never drops or duplicates a word.
- A done pulse arriving while the FSM is in LOAD_X, LOAD_Y or START is ignored.

## Test plan
Use VECTOR_SIZE=4, ADDR_WIDTH=4, N=16.
- Full run, no stalls: X = identity, Y = words 1..16, core model returns X*Y.
  - Required: out_data is 1..16 in order.
  - out_last high only on the 16th word.
  - start high exactly one cycle, at the cycle after the 32nd accept.
- Input bubbles: in_valid toggles randomly.
  - Required: X BRAM holds words 0..15 at addresses 0..15.
  - One wr_en per accepted word.
  - No write before the first accept.
- Output backpressure: out_ready = 1,0,0,1 repeating.
  - Required: all 16 Z words appear exactly once, in order.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Stale done: hold done=1 through the load phases and the START cycle.
  - Required: no DRAIN entry before the second WAIT cycle.
  - Loads are unaffected.
- Reset mid-run: assert reset after the 7th Z word is popped, then run a second job with Y = 17..32.
  - Required: out_valid=0 the cycle after reset.
  - The second job's outputs are correct, starting from Z address 0.
- Back-to-back jobs: start the second load immediately after out_last.
  - Required: in_ready=1 the cycle after the out_last pop.
  - busy is 0 for exactly that one cycle.
